// File: rtl/mul_issue_ctrl_pkg.sv
// Shared constants, FSM state type and sign-mode decode for the multiply issue controller.
package mul_issue_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        FIX    = 3'd3,
        DONE   = 3'd4,
        DRAIN  = 3'd5
    } state_e;

    // rs1 is signed for MULH and MULHSU; MUL uses the unsigned path (lo word is sign-independent)
    function automatic logic is_a_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU);
    endfunction

    // rs2 is signed only for MULH
    function automatic logic is_b_signed(input logic [2:0] f3);
        return (f3 == F3_MULH);
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// EX-stage request/response and multiplier launch/return signals.
interface mul_issue_ctrl_if #(
    parameter int unsigned XLEN = mul_issue_ctrl_pkg::XLEN
);
    logic                ex_valid;
    logic [2:0]          funct3;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic                flush;
    logic                mul_stall;
    logic                mul_done;
    logic [XLEN-1:0]     mul_result;
    logic                m_in_valid;
    logic [XLEN-1:0]     m_mplier;
    logic [XLEN-1:0]     m_mcand;
    logic [2*XLEN-1:0]   m_product;
    logic                m_out_valid;

    // Controller side
    modport slave (
        input  ex_valid, funct3, rs1, rs2, flush, m_product, m_out_valid,
        output mul_stall, mul_done, mul_result, m_in_valid, m_mplier, m_mcand
    );

    // EX stage / multiplier side
    modport master (
        output ex_valid, funct3, rs1, rs2, flush, m_product, m_out_valid,
        input  mul_stall, mul_done, mul_result, m_in_valid, m_mplier, m_mcand
    );
endinterface

// File: rtl/mul_issue_ctrl_sign_fix.sv
// Operand magnitudes for the unsigned multiplier and conditional negate of its product.
module mul_issue_ctrl_sign_fix #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic              a_signed,
    input  logic              b_signed,
    input  logic [2*XLEN-1:0] prod,
    input  logic              neg,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic [2*XLEN-1:0] fixed
);

    // Most-negative input negates to itself, which is the correct unsigned magnitude
    assign mag1  = (a_signed && rs1[XLEN-1]) ? -rs1 : rs1;
    assign mag2  = (b_signed && rs2[XLEN-1]) ? -rs2 : rs2;

    // Two's-complement negate mod 2^(2*XLEN); zero stays zero
    assign fixed = neg ? -prod : prod;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller between EX and the iterative unsigned multiplier, with a 1-entry product cache.
module mul_issue_ctrl #(
    parameter int unsigned XLEN     = mul_issue_ctrl_pkg::XLEN,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    mul_issue_ctrl_if.slave bus
);
    import mul_issue_ctrl_pkg::*;

    localparam int unsigned PW = 2 * XLEN;

    state_e            state_q,   state_d;
    logic [XLEN-1:0]   op_rs1_q,  op_rs1_d;
    logic [XLEN-1:0]   op_rs2_q,  op_rs2_d;
    logic [2:0]        op_f3_q,   op_f3_d;
    logic              neg_q,     neg_d;
    logic              sel_hi_q,  sel_hi_d;
    logic [XLEN-1:0]   mplier_q,  mplier_d;
    logic [XLEN-1:0]   mcand_q,   mcand_d;
    logic [PW-1:0]     prod_q,    prod_d;
    logic [XLEN-1:0]   result_q,  result_d;
    logic              done_q,    done_d;
    logic              launch_q,  launch_d;
    logic              c_valid_q, c_valid_d;
    logic [XLEN-1:0]   c_rs1_q,   c_rs1_d;
    logic [XLEN-1:0]   c_rs2_q,   c_rs2_d;
    logic [2:0]        c_f3_q,    c_f3_d;
    logic [PW-1:0]     c_prod_q,  c_prod_d;

    logic              a_s;
    logic              b_s;
    logic              neg_now;
    logic              hit;
    logic [XLEN-1:0]   hit_word;
    logic [XLEN-1:0]   mag1;
    logic [XLEN-1:0]   mag2;
    logic [PW-1:0]     fixed;
    logic              mul_stall_c;

    assign a_s     = is_a_signed(bus.funct3);
    assign b_s     = is_b_signed(bus.funct3);
    assign neg_now = (a_s & bus.rs1[XLEN-1]) ^ (b_s & bus.rs2[XLEN-1]);

    mul_issue_ctrl_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .rs1      (bus.rs1),
        .rs2      (bus.rs2),
        .a_signed (a_s),
        .b_signed (b_s),
        .prod     (prod_q),
        .neg      (neg_q),
        .mag1     (mag1),
        .mag2     (mag2),
        .fixed    (fixed)
    );

    // Cache lookup: a MUL hits any cached mode since the lo word does not depend on signedness
    always_comb begin
        hit = CACHE_EN && c_valid_q
              && (bus.rs1 == c_rs1_q) && (bus.rs2 == c_rs2_q)
              && ((bus.funct3 == F3_MUL) || (bus.funct3 == c_f3_q));
        hit_word = (bus.funct3 == F3_MUL) ? c_prod_q[XLEN-1:0] : c_prod_q[PW-1:XLEN];
    end

    // Pipeline hold: released in DONE or on flush; while draining it simply follows ex_valid
    always_comb begin
        mul_stall_c = 1'b0;
        if (!rst_n) begin
            case (state_q)
                DRAIN:   mul_stall_c = bus.ex_valid;
                DONE:    mul_stall_c = 1'b0;
                default: mul_stall_c = bus.ex_valid & ~bus.flush;
            endcase
        end
    end

    // Next-state, datapath capture and cache update
    always_comb begin
        state_d   = state_q;
        op_rs1_d  = op_rs1_q;
        op_rs2_d  = op_rs2_q;
        op_f3_d   = op_f3_q;
        neg_d     = neg_q;
        sel_hi_d  = sel_hi_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        result_d  = result_q;
        done_d    = 1'b0;
        launch_d  = 1'b0;
        c_valid_d = c_valid_q;
        c_rs1_d   = c_rs1_q;
        c_rs2_d   = c_rs2_q;
        c_f3_d    = c_f3_q;
        c_prod_d  = c_prod_q;

        case (state_q)
            IDLE: begin
                if (bus.ex_valid && !bus.flush) begin
                    if (hit) begin
                        result_d = hit_word;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end else begin
                        op_rs1_d = bus.rs1;
                        op_rs2_d = bus.rs2;
                        op_f3_d  = bus.funct3;
                        neg_d    = neg_now;
                        sel_hi_d = (bus.funct3 != F3_MUL);
                        mplier_d = mag1;
                        mcand_d  = mag2;
                        launch_d = 1'b1;
                        state_d  = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // The launch pulse is already out, so a flush must still absorb its product
                state_d = bus.flush ? DRAIN : WAIT;
            end
            WAIT: begin
                if (bus.m_out_valid) begin
                    prod_d  = bus.m_product;
                    state_d = bus.flush ? IDLE : FIX;
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end
            end
            FIX: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else begin
                    result_d = sel_hi_q ? fixed[PW-1:XLEN] : fixed[XLEN-1:0];
                    done_d   = 1'b1;
                    state_d  = DONE;
                    if (CACHE_EN) begin
                        c_valid_d = 1'b1;
                        c_rs1_d   = op_rs1_q;
                        c_rs2_d   = op_rs2_q;
                        c_f3_d    = op_f3_q;
                        c_prod_d  = fixed;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            DRAIN: begin
                if (bus.m_out_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous active-high reset clears everything
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q   <= IDLE;
            op_rs1_q  <= '0;
            op_rs2_q  <= '0;
            op_f3_q   <= '0;
            neg_q     <= 1'b0;
            sel_hi_q  <= 1'b0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            launch_q  <= 1'b0;
            c_valid_q <= 1'b0;
            c_rs1_q   <= '0;
            c_rs2_q   <= '0;
            c_f3_q    <= '0;
            c_prod_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_rs1_q  <= op_rs1_d;
            op_rs2_q  <= op_rs2_d;
            op_f3_q   <= op_f3_d;
            neg_q     <= neg_d;
            sel_hi_q  <= sel_hi_d;
            mplier_q  <= mplier_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            result_q  <= result_d;
            done_q    <= done_d;
            launch_q  <= launch_d;
            c_valid_q <= c_valid_d;
            c_rs1_q   <= c_rs1_d;
            c_rs2_q   <= c_rs2_d;
            c_f3_q    <= c_f3_d;
            c_prod_q  <= c_prod_d;
        end
    end

    // A flush arriving in DONE still kills the completion
    assign bus.mul_stall  = mul_stall_c;
    assign bus.mul_done   = done_q & ~bus.flush & ~rst_n;
    assign bus.mul_result = result_q;
    assign bus.m_in_valid = launch_q;
    assign bus.m_mplier   = mplier_q;
    assign bus.m_mcand    = mcand_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with an iterative multiplier model of programmable latency.
module tb_mul_issue_ctrl;
    import mul_issue_ctrl_pkg::*;

    logic clk;
    logic rst_n;
    int   lat;
    int   cnt;
    int   total;
    int   bad;

    mul_issue_ctrl_if #(.XLEN(32)) bus ();

    mul_issue_ctrl #(
        .XLEN     (32),
        .CACHE_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: out_valid arrives lat cycles after the in_valid cycle
    always @(posedge clk) begin
        if (rst_n) begin
            bus.m_out_valid <= 1'b0;
            bus.m_product   <= '0;
            cnt             <= 0;
        end else begin
            bus.m_out_valid <= 1'b0;
            if (bus.m_in_valid) begin
                bus.m_product <= 64'(bus.m_mplier) * 64'(bus.m_mcand);
                if (lat <= 1) bus.m_out_valid <= 1'b1;
                else          cnt <= lat - 1;
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) bus.m_out_valid <= 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Wait for mul_done with the current request held; counts cycles and launch pulses
    task automatic wait_done(output logic [31:0] res, output int cycles, output int launches,
                             output bit stall_ok, output bit to);
        bit done;
        res = '0; cycles = 0; launches = 0; stall_ok = 1'b1; to = 1'b0; done = 1'b0;
        while (!done && !to) begin
            @(negedge clk);
            cycles++;
            if (bus.m_in_valid) launches++;
            if (bus.mul_done) begin
                res  = bus.mul_result;
                done = 1'b1;
                if (bus.mul_stall) stall_ok = 1'b0;
            end else begin
                if (!bus.mul_stall) stall_ok = 1'b0;
                if (cycles >= 200) to = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
    endtask

    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int cycles, output int launches,
                         output bit stall_ok, output bit to);
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b1;
        bus.funct3   = f3;
        bus.rs1      = a;
        bus.rs2      = b;
        wait_done(res, cycles, launches, stall_ok, to);
    endtask

    // Runs one op and checks result, launch count, latency, stall and timeout
    task automatic op_check(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int exp_l,
                            input int exp_c);
        logic [31:0] res;
        int          cyc;
        int          nl;
        bit          sok;
        bit          to;
        do_op(f3, a, b, res, cyc, nl, sok, to);
        chk({tag, " timeout"}, 64'(to), 64'(0));
        chk({tag, " result"}, 64'(res), 64'(exp));
        chk({tag, " launches"}, 64'(nl), 64'(exp_l));
        chk({tag, " cycles"}, 64'(cyc), 64'(exp_c));
        chk({tag, " stall"}, 64'(sok), 64'(1));
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " mul_stall"}, 64'(bus.mul_stall), 64'(0));
        chk({tag, " mul_done"}, 64'(bus.mul_done), 64'(0));
        chk({tag, " mul_result"}, 64'(bus.mul_result), 64'(0));
        chk({tag, " m_in_valid"}, 64'(bus.m_in_valid), 64'(0));
        chk({tag, " m_mplier"}, 64'(bus.m_mplier), 64'(0));
        chk({tag, " m_mcand"}, 64'(bus.m_mcand), 64'(0));
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          launches;
        int          cycles;
        logic [31:0] mpl;
        logic [31:0] mcd;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [31:0] res;
        int          cyc;
        int          nl;
        int          n;
        bit          sok;
        bit          to;

        total = 0;
        bad   = 0;
        lat   = 4;

        // lat=4: miss = 4 + lat = 8 cycles, hit = 2 cycles; mpl/mcd are the held magnitudes
        vecs[0]  = '{F3_MUL,    32'd7,         32'd6,         32'h0000002A, 1, 8, 32'd7,         32'd6};
        vecs[1]  = '{F3_MULH,   32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFF, 1, 8, 32'd1,         32'd2};
        vecs[2]  = '{F3_MUL,    32'hFFFFFFFF,  32'h00000002,  32'hFFFFFFFE, 0, 2, 32'd1,         32'd2};
        vecs[3]  = '{F3_MULHSU, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 1, 8, 32'h80000000,  32'hFFFFFFFF};
        vecs[4]  = '{F3_MULHU,  32'h80000000,  32'hFFFFFFFF,  32'h7FFFFFFF, 1, 8, 32'h80000000,  32'hFFFFFFFF};
        vecs[5]  = '{F3_MULH,   32'h80000000,  32'h80000000,  32'h40000000, 1, 8, 32'h80000000,  32'h80000000};
        vecs[6]  = '{F3_MULH,   32'h00000000,  32'h80000000,  32'h00000000, 1, 8, 32'h00000000,  32'h80000000};
        vecs[7]  = '{F3_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 1, 8, 32'hFFFFFFFF,  32'hFFFFFFFF};
        vecs[8]  = '{F3_MUL,    32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001, 0, 2, 32'hFFFFFFFF,  32'hFFFFFFFF};
        vecs[9]  = '{F3_MULH,   32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 1, 8, 32'd1,         32'd1};
        vecs[10] = '{F3_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF, 1, 8, 32'd1,         32'hFFFFFFFF};
        vecs[11] = '{F3_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFF, 0, 2, 32'd1,         32'hFFFFFFFF};
        vecs[12] = '{F3_MUL,    32'd3,         32'hFFFFFFFB,  32'hFFFFFFF1, 1, 8, 32'd3,         32'hFFFFFFFB};
        vecs[13] = '{F3_MULH,   32'hFFFFFFFD,  32'd5,         32'hFFFFFFFF, 1, 8, 32'd3,         32'd5};
        vecs[14] = '{F3_MULH,   32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF, 1, 8, 32'h7FFFFFFF,  32'h7FFFFFFF};
        vecs[15] = '{F3_MULHSU, 32'h40000000,  32'd4,         32'h00000001, 1, 8, 32'h40000000,  32'd4};

        bus.ex_valid = 1'b0;
        bus.funct3   = 3'b000;
        bus.rs1      = '0;
        bus.rs2      = '0;
        bus.flush    = 1'b0;
        rst_n        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b0;

        for (int i = 0; i < 16; i++) begin
            op_check($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b,
                     vecs[i].exp, vecs[i].launches, vecs[i].cycles);
            chk($sformatf("vec%0d m_mplier", i), 64'(bus.m_mplier), 64'(vecs[i].mpl));
            chk($sformatf("vec%0d m_mcand", i), 64'(bus.m_mcand), 64'(vecs[i].mcd));
        end

        // Flush in the 5th WAIT cycle, next op queued behind the drain
        lat = 10;
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b1;
        bus.funct3   = F3_MULHU;
        bus.rs1      = 32'h10;
        bus.rs2      = 32'h20;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_in_valid && n < 20);
        chk("flush op launch", 64'(bus.m_in_valid), 64'(1));
        repeat (5) @(posedge clk);
        #1;
        bus.flush = 1'b1;
        @(negedge clk);
        chk("flush cycle stall", 64'(bus.mul_stall), 64'(0));
        chk("flush cycle done", 64'(bus.mul_done), 64'(0));
        @(posedge clk);
        #1;
        bus.flush  = 1'b0;
        bus.funct3 = F3_MUL;
        bus.rs1    = 32'd3;
        bus.rs2    = 32'd5;
        wait_done(res, cyc, nl, sok, to);
        chk("drain timeout", 64'(to), 64'(0));
        chk("drain result", 64'(res), 64'(15));
        chk("drain launches", 64'(nl), 64'(1));
        chk("drain cycles", 64'(cyc), 64'(19));
        chk("drain stall", 64'(sok), 64'(1));
        lat = 4;
        op_check("after drain hit", F3_MUL, 32'd3, 32'd5, 32'd15, 0, 2);
        op_check("killed op miss", F3_MULHU, 32'h10, 32'h20, 32'd0, 1, 8);

        // Reset in the middle of WAIT; the previously cached op must miss afterwards
        op_check("pre-reset op", F3_MUL, 32'd9, 32'd9, 32'h51, 1, 8);
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b1;
        bus.funct3   = F3_MULHU;
        bus.rs1      = 32'hFFFFFFFF;
        bus.rs2      = 32'h10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.m_in_valid && n < 20);
        chk("reset op launch", 64'(bus.m_in_valid), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_outputs_zero("mid-op reset");
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.ex_valid = 1'b0;
        op_check("post-reset repeat", F3_MUL, 32'd9, 32'd9, 32'h51, 1, 8);
        op_check("post-reset killed", F3_MULHU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 1, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
